mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable memory-side responder for the tagged proc2mem/mem2proc bus; the D-cache (and I-cache) is the initiator.
- Accepts one LOAD/STORE command per cycle and returns a nonzero transaction tag in the same cycle.
- Delivers data with the matching tag exactly MEM_LATENCY cycles later.
- Replaces the behavioural memory model on the cache benches and serves as the backing store in synthesized tests.

Parameters:
- MEM_LATENCY, 4, cycles from acceptance to tagged completion (1..14).
- NUM_TAGS, 15, allocatable tags 1..NUM_TAGS; tag 0 means "no response / no completion".
- MEM_WORDS, 1024, number of 64-bit words of backing storage.
- STALL_PERIOD, 8, rejection period; used only with MEM_STALL_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- proc2mem_command  in  2  0 BUS_NONE, 1 BUS_LOAD, 2 BUS_STORE, 3 ignored (treated as NONE).
- proc2mem_addr  in  XLEN  byte address; bits [2:0] are ignored.
- proc2mem_data  in  64  store data.
- mem2proc_response  out  4  tag allocated this cycle; 0 means rejected or idle.
- mem2proc_data  out  64  completion data, valid when mem2proc_tag != 0.
- mem2proc_tag  out  4  tag completing this cycle; 0 means none.

Behaviour:
- Word index: addr[$clog2(MEM_WORDS)+2:3]. Higher address bits are truncated, so addresses wrap.
- Response path is combinational:
  - mem2proc_response = lowest-numbered free tag when the command is LOAD/STORE and a tag is free; otherwise 0.
  - Allocation commits at the posedge ending the cycle.
  - The requester must hold the command until it sees a nonzero response. A zero response is a reject and has no side effects.
- LOAD accepted in cycle N:
  - The word is read in cycle N and captured into a per-tag data buffer, so later stores do not alter it.
  - mem2proc_tag = tag and mem2proc_data = captured word, registered, visible throughout cycle N+MEM_LATENCY.
- STORE accepted in cycle N:
  - The memory word is written at the posedge ending N.
  - Completion in cycle N+MEM_LATENCY carries the tag and the stored data (write-ack).
- A LOAD in cycle N+1 to the same address as a STORE accepted in N returns the new data (write-before-read ordering).
- Per-tag state: valid bit, down-counter (width $clog2(MEM_LATENCY+1)), data buffer.
  - On allocation the counter is loaded with MEM_LATENCY-1 and decrements each cycle.
  - The tag whose counter is 0 drives the completion register.
  - Only one tag can expire per cycle because acceptance is one per cycle.
- A tag is freed at the posedge after its completion cycle; it is allocatable again one cycle after completion.
- Pool exhaustion: only possible when NUM_TAGS < MEM_LATENCY+1. Commands then receive response 0 until a tag frees. No request is ever lost.
- When mem2proc_tag == 0, mem2proc_data holds 0.
- Reset (reset==0 at a posedge):
  - All tags are invalidated and in-flight transactions dropped; no completion appears for them.
  - mem2proc_tag = 0 and mem2proc_data = 0 from the next cycle; mem2proc_response = 0 while reset is low.
  - Memory contents are not cleared.
  - A command presented during reset is not accepted.

Optional Feature:
- MEM_STALL_EN defined:
  - A free-running counter modulo STALL_PERIOD, cleared by reset.
  - In cycles where the counter == STALL_PERIOD-1, every command gets response 0. This forces initiator retry paths.
- MEM_STALL_EN undefined: no counter exists and acceptance depends only on tag availability.

Decomposition:
- sys_defs.svh holds:
  - BUS_COMMAND enum (BUS_NONE, BUS_LOAD, BUS_STORE).
  - MEM_LATENCY_IN_CYCLES default constant.
  - MEM_TAG_ENTRY struct (valid, count, data).
- Sub-module mem_tag_pool: free-tag priority encoder plus per-tag countdown and valid bits. It outputs the allocated tag and the expiring tag.
- The top level holds the storage array, data buffers, output register and stall counter.

Test Plan:
- Load latency: STORE 0x10 data 0xDEADBEEF_CAFEF00D, then LOAD 0x10 → response 1 then 2; tag 2 with data 0xDEADBEEF_CAFEF00D exactly 4 cycles after the LOAD is accepted.
- Back-to-back: LOADs to 0x0, 0x8, 0x10, 0x18 on consecutive cycles → responses 1,2,3,4; completions on consecutive cycles in the same order with the correct words.
- Read-capture: LOAD 0x20 (old 0x1111) then STORE 0x20 0x2222 the next cycle → the load completion returns 0x1111; a subsequent LOAD returns 0x2222.
- Exhaustion with NUM_TAGS=2, MEM_LATENCY=4: continuous LOADs → responses 1,2,0,0,0; tag 1 becomes reusable the cycle after its completion.
- Reset mid-flight: reset low 1 cycle while tags 1..3 are outstanding → no completions appear; outputs 0; the next LOAD gets tag 1; memory data is retained.
- MEM_STALL_EN, STALL_PERIOD=8: continuous LOADs → every 8th cycle response 0; no completion is missing or duplicated.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: bus command encoding, tag-entry layout and shared
// constants for the tagged proc2mem/mem2proc memory responder.
package mem_responder_pkg;

  // Processor-side address width.
  localparam int XLEN = 32;

  // Tag field width on the bus; tag 0 is reserved for "none".
  localparam int TAG_W = 4;

  // Largest tag value the bus can carry.
  localparam int MAX_TAGS = (1 << TAG_W) - 1;

  // Default latency from acceptance to tagged completion.
  localparam int MEM_LATENCY_IN_CYCLES = 4;

  // Bus command encoding; 2'd3 is unused and treated as BUS_NONE.
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  // Architectural view of one tag: in-flight flag, cycles left, and the
  // captured load word or stored data returned on completion.
  typedef struct packed {
    logic        valid;
    logic [3:0]  count;
    logic [63:0] data;
  } MEM_TAG_ENTRY;

  // True for commands that need a tag.
  function automatic logic is_mem_cmd(logic [1:0] cmd);
    return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
  endfunction

endpackage

// File: rtl/mem_responder_tag_pool.sv
// mem_tag_pool: allocatable tags 1..NUM_TAGS. A lowest-free priority
// encoder picks the tag offered this cycle; each tag then counts down to
// its completion cycle and is released at the edge that ends it.
module mem_tag_slot
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_IN_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic alloc,
  output logic busy,
  output logic expire
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [CNT_W-1:0] count;

  // Load the countdown on allocation; release the tag once it has expired.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (alloc) begin
      busy  <= 1'b1;
      count <= CNT_W'(MEM_LATENCY - 1);
    end else if (busy) begin
      if (count == '0) busy  <= 1'b0;
      else             count <= count - CNT_W'(1);
    end
  end

  assign expire = busy && (count == '0);

endmodule

module mem_tag_pool
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS    = 15,
  parameter int MEM_LATENCY = MEM_LATENCY_IN_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TAG_W-1:0] alloc_tag,
  output logic [TAG_W-1:0] free_tag,
  output logic [TAG_W-1:0] expire_tag
);

  logic [NUM_TAGS:1] busy;
  logic [NUM_TAGS:1] expire;

  for (genvar t = 1; t <= NUM_TAGS; t++) begin : g_slot
    mem_tag_slot #(
      .MEM_LATENCY(MEM_LATENCY)
    ) u_slot (
      .clock (clock),
      .reset (reset),
      .alloc (alloc_tag == TAG_W'(t)),
      .busy  (busy[t]),
      .expire(expire[t])
    );
  end

  // Lowest-numbered free tag; 0 when the pool is exhausted.
  always_comb begin
    free_tag = '0;
    for (int t = NUM_TAGS; t >= 1; t--)
      if (!busy[t]) free_tag = TAG_W'(t);
  end

  // Acceptance is one per cycle with a fixed latency, so at most one tag
  // expires per cycle and a plain OR-encode is sufficient.
  always_comb begin
    expire_tag = '0;
    for (int t = 1; t <= NUM_TAGS; t++)
      if (expire[t]) expire_tag = expire_tag | TAG_W'(t);
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the tagged proc2mem/mem2proc bus.
// Accepts one LOAD/STORE per cycle, returns a tag combinationally, and
// completes that tag with data exactly MEM_LATENCY cycles later.
// Optional build macro MEM_STALL_EN: reject every command one cycle in
// every STALL_PERIOD to exercise initiator retry paths.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY  = MEM_LATENCY_IN_CYCLES,
  parameter int NUM_TAGS     = 15,
  parameter int MEM_WORDS    = 1024,
  parameter int STALL_PERIOD = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2mem_command,
  input  logic [XLEN-1:0]  proc2mem_addr,
  input  logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] mem2proc_response,
  output logic [63:0]      mem2proc_data,
  output logic [TAG_W-1:0] mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 14 || NUM_TAGS < 1 ||
      NUM_TAGS > MAX_TAGS || STALL_PERIOD < 2) begin : g_bad_cfg
    $error("mem_responder: unsupported MEM_LATENCY/NUM_TAGS/STALL_PERIOD");
  end

  logic [63:0]      mem      [MEM_WORDS];
  logic [63:0]      data_buf [1 << TAG_W];
  logic [IDX_W-1:0] idx;
  logic             stall;
  logic             cmd_ok;
  logic             is_store;
  logic [TAG_W-1:0] free_tag;
  logic [TAG_W-1:0] expire_tag;

  // Low address bits select a byte within the word; high bits wrap.
  logic unused_addr;
  assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr >> (IDX_W + 3)};

  assign idx      = proc2mem_addr[IDX_W+2:3];
  assign is_store = (proc2mem_command == BUS_STORE);

`ifdef MEM_STALL_EN
  localparam int STALL_W = $clog2(STALL_PERIOD);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_PERIOD - 1);

  logic [STALL_W-1:0] stall_cnt;

  // Free-running phase counter; the last phase of each period rejects all.
  always_ff @(posedge clock) begin
    if (!reset)                    stall_cnt <= '0;
    else if (stall_cnt == STALL_LAST) stall_cnt <= '0;
    else                           stall_cnt <= stall_cnt + STALL_W'(1);
  end

  assign stall = (stall_cnt == STALL_LAST);
`else
  assign stall = 1'b0;
`endif

  // Offer a tag only to a real command outside reset and stall cycles; a
  // zero response leaves all state untouched.
  always_comb begin
    cmd_ok            = reset && is_mem_cmd(proc2mem_command) && !stall;
    mem2proc_response = cmd_ok ? free_tag : '0;
  end

  mem_tag_pool #(
    .NUM_TAGS   (NUM_TAGS),
    .MEM_LATENCY(MEM_LATENCY)
  ) u_pool (
    .clock     (clock),
    .reset     (reset),
    .alloc_tag (mem2proc_response),
    .free_tag  (free_tag),
    .expire_tag(expire_tag)
  );

  // Backing store: written at the edge ending the accepting cycle, so a
  // load in the next cycle sees the new word. Contents survive reset.
  always_ff @(posedge clock) begin
    if (mem2proc_response != '0 && is_store)
      mem[idx] <= proc2mem_data;
  end

  // Capture the word per tag at acceptance; a later store cannot alter an
  // in-flight load, and a store echoes its own data as the write-ack.
  always_ff @(posedge clock) begin
    if (mem2proc_response != '0)
      data_buf[mem2proc_response] <= is_store ? proc2mem_data : mem[idx];
  end

  // Completion is selected purely from registered tag state and buffers,
  // so it is stable for the whole completion cycle; idle data reads as 0.
  always_comb begin
    mem2proc_tag  = expire_tag;
    mem2proc_data = (expire_tag != '0) ? data_buf[expire_tag] : 64'h0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. Expected completions
// are queued at acceptance and matched against the bus each cycle.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam int NT  = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  proc2mem_command = 2'd0;
  logic [31:0] proc2mem_addr = '0;
  logic [63:0] proc2mem_data = '0;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  logic [1:0]  s_command = 2'd0;
  logic [31:0] s_addr = '0;
  logic [63:0] s_wdata = '0;
  logic [3:0]  s_response;
  logic [63:0] s_data;
  logic [3:0]  s_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          busy_until[1:NT];
  logic [63:0] mmem[int];

  mem_responder dut (
    .clock(clock), .reset(reset),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
  );

  mem_responder #(.NUM_TAGS(2), .MEM_LATENCY(4)) dut_small (
    .clock(clock), .reset(reset),
    .proc2mem_command(s_command), .proc2mem_addr(s_addr),
    .proc2mem_data(s_wdata), .mem2proc_response(s_response),
    .mem2proc_data(s_data), .mem2proc_tag(s_tag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef MEM_STALL_EN
  int m_sc = 0;
  always @(posedge clock) m_sc <= !reset ? 0 : (m_sc == 7 ? 0 : m_sc + 1);
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_resp(input logic [1:0] cmd);
    if (!reset) return 4'd0;
    if (cmd != 2'd1 && cmd != 2'd2) return 4'd0;
`ifdef MEM_STALL_EN
    if (m_sc == 7) return 4'd0;
`endif
    for (int t = 1; t <= NT; t++)
      if (busy_until[t] < cyc) return 4'(t);
    return 4'd0;
  endfunction

  // Completion monitor: expected entry when due, otherwise an idle bus.
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      for (int t = 1; t <= NT; t++) busy_until[t] = -1;
    end else if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_cpl", 64'(mem2proc_tag), 64'(sb[0].tag));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("cpl_tag", 64'(mem2proc_tag), 64'(e.tag));
        chk("cpl_data", mem2proc_data, e.data);
      end else begin
        chk("idle_tag", 64'(mem2proc_tag), 64'd0);
        chk("idle_data", mem2proc_data, 64'd0);
      end
    end
  end

  // Hold a command until it is accepted; queue its expected completion.
  task automatic issue(input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, output logic [3:0] tag);
    logic [3:0] e;
    int tries;
    bit done;
    int idx;
    tries = 0;
    done  = 1'b0;
    tag   = 4'd0;
    idx   = int'((addr >> 3) & 32'h3ff);
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = data;
    while (!done) begin
      @(negedge clock);
      e = exp_resp(cmd);
      chk("response", 64'(mem2proc_response), 64'(e));
      if (e != 4'd0) begin
        tag = e;
        busy_until[e] = cyc + LAT;
        if (cmd == 2'd2) begin
          mmem[idx] = data;
          sb.push_back('{e, data, cyc + LAT});
        end else begin
          sb.push_back('{e, mmem.exists(idx) ? mmem[idx] : 64'h0, cyc + LAT});
        end
        done = 1'b1;
      end else if (++tries > 20) begin
        chk("accept_timeout", 64'(tries), 64'd0);
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic idle();
    proc2mem_command = 2'd0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (sb.size() > 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  t;
    logic [3:0]  exh_exp [8];
    logic [63:0] w;

    for (int i = 1; i <= NT; i++) busy_until[i] = -1;
    exh_exp = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    mon_en    = 1'b1;
    s_command = 2'd1;

    // Reset state plus exhaustion on the 2-tag instance.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) begin
        chk("rst_resp", 64'(mem2proc_response), 64'd0);
        chk("rst_tag", 64'(mem2proc_tag), 64'd0);
        chk("rst_data", mem2proc_data, 64'd0);
      end
      chk("exh_resp", 64'(s_response), 64'(exh_exp[i]));
      if (i == 4) chk("exh_cpl1", 64'(s_tag), 64'd1);
      if (i == 5) chk("exh_cpl2", 64'(s_tag), 64'd2);
      @(posedge clock); #1;
    end
    s_command = 2'd0;

    // Load latency.
    issue(2'd2, 32'h10, 64'hDEADBEEF_CAFEF00D, t);
    chk("lat_store_tag", 64'(t), 64'd1);
    issue(2'd1, 32'h10, 64'h0, t);
    chk("lat_load_tag", 64'(t), 64'd2);
    idle();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("lat_cpl_tag", 64'(mem2proc_tag), 64'd2);
    chk("lat_cpl_data", mem2proc_data, 64'hDEADBEEF_CAFEF00D);
    @(posedge clock); #1;
    drain();

    // Back-to-back loads.
    issue(2'd2, 32'h0,  64'h0000_0000_AAAA_0000, t);
    issue(2'd2, 32'h8,  64'h0000_0000_AAAA_0008, t);
    issue(2'd2, 32'h18, 64'h0000_0000_AAAA_0018, t);
    drain();
    for (int i = 0; i < 4; i++) begin
      issue(2'd1, 32'(i * 8), 64'h0, t);
      chk("b2b_tag", 64'(t), 64'(i + 1));
    end
    drain();

    // Read capture versus a following store.
    issue(2'd2, 32'h20, 64'h1111, t);
    drain();
    issue(2'd1, 32'h20, 64'h0, t);
    issue(2'd2, 32'h20, 64'h2222, t);
    issue(2'd1, 32'h20, 64'h0, t);
    drain();

    // Address wrap and ignored offset bits alias word 4.
    issue(2'd1, 32'h2025, 64'h0, t);
    drain();

    // Command encoding 3 is ignored.
    proc2mem_command = 2'd3;
    proc2mem_addr    = 32'h8;
    @(negedge clock);
    chk("cmd3_resp", 64'(mem2proc_response), 64'd0);
    @(posedge clock); #1;
    drain();

    // Reset while three loads are in flight.
    issue(2'd1, 32'h0,  64'h0, t);
    issue(2'd1, 32'h8,  64'h0, t);
    issue(2'd1, 32'h10, 64'h0, t);
    reset = 1'b0;
    proc2mem_command = 2'd1;
    proc2mem_addr    = 32'h20;
    @(negedge clock);
    chk("rst_cmd_resp", 64'(mem2proc_response), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle();
    repeat (4) @(posedge clock);
    #1;
    issue(2'd1, 32'h20, 64'h0, t);
    chk("rst_newtag", 64'(t), 64'd1);
    drain();

    // Random mix over 16 words.
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom};
      issue(2'd2, 32'(i * 8), w, t);
    end
    for (int i = 0; i < 40; i++) begin
      w = {$urandom, $urandom};
      issue($urandom_range(0, 1) ? 2'd2 : 2'd1, 32'($urandom_range(0, 15) * 8), w, t);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
